// File: rtl/divider_pkg.sv
// Shared types and defaults for the sequential restoring divider.
// Optional divide-by-zero short-cut is selected by DIV_ZERO_CHECK_EN (see booth_divider).
package divider_pkg;

    localparam int DIV_W_DEFAULT = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        DONE = 2'd2
    } div_state_t;

endpackage

// File: rtl/div_count_down.sv
// Loadable down-counter that sequences the divider's iteration steps.
// zero is high while idle at zero, or while enabled and about to reach zero.
module div_count_down #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] n_i,
    input  logic         en,
    output logic         zero
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= n_i;
        end else if (en && (cnt_q != '0)) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    // Look-ahead while enabled so the FSM can leave ITER on the edge that empties the count.
    assign zero = en ? (cnt_q == W'(1)) : (cnt_q == '0);

endmodule

// File: rtl/booth_divider.sv
// Sequential unsigned restoring divider, one quotient bit per clock, valid/done handshake.
// Define DIV_ZERO_CHECK_EN to short-cut a zero divisor straight from IDLE to DONE.
module booth_divider
    import divider_pkg::*;
#(
    parameter int N = DIV_W_DEFAULT
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         valid,
    input  logic [N-1:0] dividend,
    input  logic [N-1:0] divisor,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] quotient,
    output logic [N-1:0] remainder,
    output logic         div_by_zero,
    output div_state_t   state_dbg
);

    // Handshake: valid is a start request sampled only in IDLE; it is ignored, not queued,
    // while busy. done pulses for exactly one cycle, and quotient/remainder stay stable until
    // the next capture.

    localparam int CW = $clog2(N + 1);

    div_state_t   state_q, state_d;
    logic         capture;
    logic         cnt_load;
    logic         cnt_en;
    logic         cnt_zero;
    logic         zero_cap;

    logic [N-1:0] m_q;
    logic [N:0]   a_q;
    logic [N-1:0] q_q;
    logic [N:0]   s;
    logic [N:0]   a_next;
    logic [N-1:0] q_next;
    logic         unused_sign;

    div_count_down #(
        .W(CW)
    ) u_count (
        .clk  (clk),
        .rst  (rst),
        .load (cnt_load),
        .n_i  (CW'(N)),
        .en   (cnt_en),
        .zero (cnt_zero)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        capture  = 1'b0;
        cnt_load = 1'b0;
        cnt_en   = 1'b0;
        zero_cap = 1'b0;
        case (state_q)
            IDLE: begin
                if (valid) begin
                    capture  = 1'b1;
                    cnt_load = 1'b1;
`ifdef DIV_ZERO_CHECK_EN
                    if (divisor == '0) begin
                        zero_cap = 1'b1;
                        state_d  = DONE;
                    end else begin
                        state_d  = ITER;
                    end
`else
                    state_d = ITER;
`endif
                end
            end
            ITER: begin
                cnt_en = 1'b1;
                if (cnt_zero) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Trial subtraction of the divisor from the shifted partial remainder.
    assign s = {a_q[N-1:0], q_q[N-1]} - {1'b0, m_q};

    always_comb begin
        if (s[N]) begin
            a_next = {a_q[N-1:0], q_q[N-1]};
            q_next = {q_q[N-2:0], 1'b0};
        end else begin
            a_next = s;
            q_next = {q_q[N-2:0], 1'b1};
        end
    end

    // The remainder stays below the divisor, so A's sign bit never feeds the next step.
    assign unused_sign = a_q[N];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_q       <= '0;
            a_q       <= '0;
            q_q       <= '0;
            quotient  <= '0;
            remainder <= '0;
        end else begin
            if (capture) begin
                m_q <= divisor;
                q_q <= dividend;
                a_q <= '0;
            end else if (state_q == ITER) begin
                a_q <= a_next;
                q_q <= q_next;
            end
            // Results only change on the edge that enters DONE.
            if (state_d == DONE) begin
                if (zero_cap) begin
                    quotient  <= '1;
                    remainder <= dividend;
                end else begin
                    quotient  <= q_next;
                    remainder <= a_next[N-1:0];
                end
            end
        end
    end

`ifdef DIV_ZERO_CHECK_EN
    logic dbz_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dbz_q <= 1'b0;
        end else if (state_d == DONE) begin
            dbz_q <= zero_cap;
        end else begin
            dbz_q <= 1'b0;
        end
    end

    assign div_by_zero = dbz_q;
`else
    assign div_by_zero = 1'b0;
`endif

    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);
    assign state_dbg = state_q;

endmodule

// File: tb/tb_booth_divider.sv
// Self-checking bench for booth_divider (N=8) with a scoreboard of expected results.
// Builds with or without DIV_ZERO_CHECK_EN; expectations follow the macro.
module tb_booth_divider;
    import divider_pkg::*;

    localparam int N  = 8;
    localparam int EW = 1 + 4 * N;  // {dbz, dividend, divisor, quotient, remainder}

`ifdef DIV_ZERO_CHECK_EN
    localparam logic DBZ_EN = 1'b1;
`else
    localparam logic DBZ_EN = 1'b0;
`endif

    logic         clk;
    logic         rst;
    logic         valid;
    logic [N-1:0] dividend;
    logic [N-1:0] divisor;
    logic         busy;
    logic         done;
    logic [N-1:0] quotient;
    logic [N-1:0] remainder;
    logic         div_by_zero;
    div_state_t   state_dbg;

    logic [EW-1:0] exp_q[$];
    int            n_checks;
    int            n_errors;
    int            done_cnt;
    int            lat;
    int            busy_cyc;

    booth_divider #(.N(N)) dut (
        .clk        (clk),
        .rst        (rst),
        .valid      (valid),
        .dividend   (dividend),
        .divisor    (divisor),
        .busy       (busy),
        .done       (done),
        .quotient   (quotient),
        .remainder  (remainder),
        .div_by_zero(div_by_zero),
        .state_dbg  (state_dbg)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic push_exp(input logic [N-1:0] dd, input logic [N-1:0] dv);
        logic [N-1:0] eq, er;
        logic         ed;
        if (dv == '0) begin
            eq = '1;
            er = dd;
            ed = DBZ_EN;
        end else begin
            eq = dd / dv;
            er = dd % dv;
            ed = 1'b0;
        end
        exp_q.push_back({ed, dd, dv, eq, er});
    endtask

    // Called #1 after a rising edge; the next edge captures.
    task automatic start_op(input logic [N-1:0] dd, input logic [N-1:0] dv, input bit expect_it);
        valid    = 1'b1;
        dividend = dd;
        divisor  = dv;
        if (expect_it) push_exp(dd, dv);
        @(posedge clk);
        #1;
        valid = 1'b0;
    endtask

    // Called #1 after the capture edge; lat counts edges from capture (inclusive) to done.
    task automatic wait_done(output int l, output int b);
        l = 1;
        b = busy ? 1 : 0;
        while (!done && l < 4 * N + 10) begin
            @(posedge clk);
            #1;
            l++;
            if (busy) b++;
        end
        if (!done) check("timeout_done", 32'd0, 32'd1);
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // ---------------- scoreboard monitor ----------------
    logic [EW-1:0] ent;
    logic [N-1:0]  e_dd, e_dv, e_q, e_r;
    logic          e_dbz;

    always begin
        @(posedge clk);
        #1;
        if (!rst && done) begin
            done_cnt++;
            if (exp_q.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                ent = exp_q.pop_front();
                {e_dbz, e_dd, e_dv, e_q, e_r} = ent;
                check("quotient", 32'(quotient), 32'(e_q));
                check("remainder", 32'(remainder), 32'(e_r));
                check("div_by_zero", 32'(div_by_zero), 32'(e_dbz));
                if (e_dv != '0) begin
                    check("q_times_d_plus_r", 32'(quotient) * 32'(e_dv) + 32'(remainder), 32'(e_dd));
                    check("r_lt_d", 32'(remainder < e_dv), 32'd1);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int d0;
        logic [N-1:0] rdd, rdv;
        n_checks = 0;
        n_errors = 0;
        done_cnt = 0;
        rst      = 1'b1;
        valid    = 1'b0;
        dividend = '0;
        divisor  = '0;
        idle_cycles(3);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_quotient", 32'(quotient), 32'd0);
        check("rst_remainder", 32'(remainder), 32'd0);
        check("rst_dbz", 32'(div_by_zero), 32'd0);
        rst = 1'b0;
        idle_cycles(2);

        // 100/7: latency and busy length
        start_op(8'd100, 8'd7, 1'b1);
        wait_done(lat, busy_cyc);
        check("lat_100_7", 32'(lat), 32'(N + 1));
        check("busy_100_7", 32'(busy_cyc), 32'(N + 1));
        idle_cycles(1);
        check("busy_after_done", 32'(busy), 32'd0);
        check("done_one_cycle", 32'(done), 32'd0);
        idle_cycles(3);
        check("hold_quotient", 32'(quotient), 32'd14);
        check("hold_remainder", 32'(remainder), 32'd2);

        // back-to-back: issue in the IDLE cycle right after each done
        start_op(8'd255, 8'd1, 1'b1);
        wait_done(lat, busy_cyc);
        idle_cycles(1);
        start_op(8'd5, 8'd9, 1'b1);
        wait_done(lat, busy_cyc);
        check("lat_b2b", 32'(lat), 32'(N + 1));
        idle_cycles(1);

        // zero divisor
        start_op(8'd200, 8'd0, 1'b1);
        wait_done(lat, busy_cyc);
        check("lat_div0", 32'(lat), DBZ_EN ? 32'd1 : 32'(N + 1));
        idle_cycles(2);

        // valid during ITER is ignored
        d0 = done_cnt;
        start_op(8'd100, 8'd7, 1'b1);
        idle_cycles(2);
        start_op(8'd50, 8'd3, 1'b0);
        idle_cycles(3 * N);
        check("single_done", 32'(done_cnt - d0), 32'd1);
        check("ignored_quotient", 32'(quotient), 32'd14);
        check("ignored_remainder", 32'(remainder), 32'd2);

        // asynchronous reset mid-ITER
        start_op(8'd100, 8'd7, 1'b1);
        idle_cycles(3);
        #2;
        rst = 1'b1;
        #1;
        exp_q.delete();
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_done", 32'(done), 32'd0);
        check("arst_quotient", 32'(quotient), 32'd0);
        check("arst_remainder", 32'(remainder), 32'd0);
        check("arst_dbz", 32'(div_by_zero), 32'd0);
        check("arst_state", 32'(state_dbg), 32'(IDLE));
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle_cycles(1);
        start_op(8'd9, 8'd3, 1'b1);
        wait_done(lat, busy_cyc);
        idle_cycles(1);

        // random sweep, non-zero divisors
        for (int i = 0; i < 1000; i++) begin
            rdd = N'($urandom_range(0, (1 << N) - 1));
            rdv = N'($urandom_range(1, (1 << N) - 1));
            start_op(rdd, rdv, 1'b1);
            wait_done(lat, busy_cyc);
            idle_cycles(1);
        end

        idle_cycles(2);
        check("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
